rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline WB stage and multi-cycle
//  units (divider/M-ext) that complete out of order. Buffers multi-cycle results and keeps a
//  pending-rd scoreboard that ID uses to stall RAW/WAW hazards. Drives the regfile write port directly.
// PARAMETERS
//  FIFO_DEPTH   2  multi-cycle result buffer entries (power of 2, >=2)
//  STARVE_LIM   4  consecutive pipeline-write cycles with a non-empty FIFO before a forced drain
// PORTS
//  clk            in   1               system clock
//  nrst           in   1               synchronous active-low reset
//  pipe_wr_en     in   1               WB stage write request (highest priority)
//  pipe_wr_addr   in   `REGFILE_BITS   WB destination register
//  pipe_wr_data   in   `WORD_WIDTH     WB data
//  mc_issue       in   1               ID issues a multi-cycle op this cycle
//  mc_issue_rd    in   `REGFILE_BITS   its destination register
//  mc_issue_ok    out  1               issue permitted (rd not pending, outstanding < FIFO_DEPTH)
//  mc_valid       in   1               multi-cycle result valid
//  mc_rd          in   `REGFILE_BITS   result destination
//  mc_data        in   `WORD_WIDTH     result data
//  mc_ready       out  1               result accepted (valid & ready = transfer)
//  id_src1_addr   in   `REGFILE_BITS   ID source 1
//  id_src2_addr   in   `REGFILE_BITS   ID source 2
//  id_dest_addr   in   `REGFILE_BITS   ID destination
//  id_hazard      out  1               any ID register pending -> ID must stall
//  pipe_stall     out  1               forced drain: WB must hold, pipe_wr_en ignored this cycle
//  rf_wr_en       out  1               to regfile wr_en
//  rf_dest_addr   out  `REGFILE_BITS   to regfile dest_addr
//  rf_wr_data     out  `WORD_WIDTH     to regfile wr_data
// BEHAVIOUR
//  - Reset (nrst low at posedge): FIFO empty, pending=0, outstanding=0, starve_cnt=0. While nrst low,
//    combinational outputs forced: rf_wr_en=0, pipe_stall=0, mc_ready=0, mc_issue_ok=0, id_hazard=0.
//  - rf_* are combinational; write lands on the same posedge the regfile samples (0-cycle arbitration).
//  - Write-port select, in priority order:
//    1 pipe_stall=1 -> FIFO head; 2 pipe_wr_en -> pipeline; 3 FIFO non-empty -> head;
//    4 FIFO empty & mc_valid -> mc bypass (mc_ready=1, no push); 5 else rf_wr_en=0.
//  - mc_ready = !full | head popped this cycle. Accepted result not bypassed is pushed.
//  - mc_rd==0: accepted, discarded (no push/write); pending unaffected, outstanding decremented.
//  - Scoreboard: pending[rd] set on mc_issue & mc_issue_ok & rd!=0; cleared when that rd is written
//    via FIFO head or bypass. x0 never pending. Set and clear cannot hit the same rd in one cycle
//    (issue blocked while pending).
//  - outstanding: +1 on issue, -1 on mc write/discard, both same cycle -> unchanged. Max FIFO_DEPTH,
//    so the FIFO cannot overflow.
//  - id_hazard = pending[src1] | pending[src2] | pending[dest] (WAW guard); index 0 always 0.
//  - Starvation: starve_cnt increments each cycle pipe_wr_en=1 with FIFO non-empty, clears otherwise.
//    At STARVE_LIM, pipe_stall=1 for one cycle, head drains, counter clears.
//  - FIFO full and pipe_wr_en=1: mc_ready=0 (backpressure); no data lost.
//  - Reset mid-operation discards buffered results; regfile reset clears contents.
// STRUCTURE
//  - Use `WORD_WIDTH, `REGFILE_BITS, `REGFILE_SIZE from constants.vh; add `MC_FIFO_DEPTH and
//    `WB_STARVE_LIM defaults there.
//  - One sub-module: wb_result_fifo (sync FIFO of {rd,data}, push/pop/full/empty, same-cycle push+pop).
//  - Top holds arbitration mux, scoreboard, outstanding and starvation counters.
// TESTING
//  1 Reset: nrst=0 2 cycles with all requests high -> rf_wr_en=0, mc_ready=0, id_hazard=0.
//  2 Bypass: FIFO empty, pipe idle, issue rd=5, mc_valid rd=5 data=0xDEADBEEF -> same-cycle write
//    x5, pending[5] clears next cycle, id_hazard drops for src1=5.
//  3 Contention: pipe writes x1 every cycle, two mc results x6,x7 -> both buffered; third mc_valid
//    sees mc_ready=0; pipe_stall pulses after 4 pipe cycles; x6 then x7 written in order.
//  4 Hazard: issue rd=9, ID src2=9 -> id_hazard=1 until x9 written; mc_issue rd=9 -> mc_issue_ok=0.
//  5 x0: issue rd=0 and mc result rd=0 -> mc_ready=1, no regfile write, outstanding back to 0.
//  6 Reset mid-op: FIFO holds 2 entries, nrst=0 one cycle -> no writes, pending=0, mc_issue_ok=1 after.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and default sizing for the register-file write-back arbiter.
package rf_wb_arbiter_pkg;

    localparam int WORD_WIDTH    = 32;
    localparam int REGFILE_BITS  = 5;
    localparam int REGFILE_SIZE  = 32;
    localparam int MC_FIFO_DEPTH = 2;
    localparam int WB_STARVE_LIM = 4;

    // One buffered multi-cycle result: destination register plus data.
    typedef struct packed {
        logic [REGFILE_BITS-1:0] rd;
        logic [WORD_WIDTH-1:0]   data;
    } wb_entry_t;

    // Which source owns the regfile write port this cycle.
    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_PIPE   = 2'd1,
        SEL_HEAD   = 2'd2,
        SEL_BYPASS = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/rf_wb_arbiter_wb_result_fifo.sv
// Synchronous FIFO of multi-cycle results. Supports push and pop in the same
// cycle, including a push into a full FIFO when the head is popped.
module wb_result_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = MC_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      nrst,
    input  logic      push_i,
    input  wb_entry_t push_entry_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr_q, rd_ptr_q;
    wb_entry_t   mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

    // A pop frees a slot in the same cycle, so a full FIFO may still take a push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer update; reset empties the FIFO and drops any buffered results.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_entry_i;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: the in-order WB stage has priority, multi-cycle
// results are buffered or bypassed, a pending-rd scoreboard flags ID hazards, and a
// starvation counter forces a FIFO drain when WB monopolises the port too long.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = MC_FIFO_DEPTH,
    parameter int STARVE_LIM = WB_STARVE_LIM
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    pipe_wr_en,
    input  logic [REGFILE_BITS-1:0] pipe_wr_addr,
    input  logic [WORD_WIDTH-1:0]   pipe_wr_data,
    input  logic                    mc_issue,
    input  logic [REGFILE_BITS-1:0] mc_issue_rd,
    output logic                    mc_issue_ok,
    input  logic                    mc_valid,
    input  logic [REGFILE_BITS-1:0] mc_rd,
    input  logic [WORD_WIDTH-1:0]   mc_data,
    output logic                    mc_ready,
    input  logic [REGFILE_BITS-1:0] id_src1_addr,
    input  logic [REGFILE_BITS-1:0] id_src2_addr,
    input  logic [REGFILE_BITS-1:0] id_dest_addr,
    output logic                    id_hazard,
    output logic                    pipe_stall,
    output logic                    rf_wr_en,
    output logic [REGFILE_BITS-1:0] rf_dest_addr,
    output logic [WORD_WIDTH-1:0]   rf_wr_data
);

    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);

    logic [REGFILE_SIZE-1:0] pending_q, pending_d;
    logic [OW-1:0]           outst_q, outst_d;
    logic [SW-1:0]           starve_q, starve_d;

    wb_sel_e   sel;
    wb_entry_t head;
    wb_entry_t push_entry;
    logic      fifo_full, fifo_empty;
    logic      pop, push, accept, mc_zero, bypass_wr, mc_retire, issue_fire;

    wb_result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .nrst        (nrst),
        .push_i      (push),
        .push_entry_i(push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Forced drain once WB has held the port for STARVE_LIM cycles over a waiting result.
    assign pipe_stall = nrst && (starve_q >= SW'(STARVE_LIM)) && !fifo_empty;

    // Write-port owner in priority order: forced drain, WB, buffered head, bypass.
    always_comb begin
        sel = SEL_NONE;
        if (!nrst)                sel = SEL_NONE;
        else if (pipe_stall)      sel = SEL_HEAD;
        else if (pipe_wr_en)      sel = SEL_PIPE;
        else if (!fifo_empty)     sel = SEL_HEAD;
        else if (mc_valid)        sel = SEL_BYPASS;
    end

    assign pop        = (sel == SEL_HEAD);
    assign mc_ready   = nrst && (!fifo_full || pop);
    assign accept     = mc_valid && mc_ready;
    assign mc_zero    = (mc_rd == '0);
    assign bypass_wr  = (sel == SEL_BYPASS) && !mc_zero;
    // Results for x0 are swallowed; everything else not bypassed is buffered.
    assign push       = accept && !mc_zero && (sel != SEL_BYPASS);
    assign mc_retire  = accept && ((sel == SEL_BYPASS) || mc_zero);
    assign push_entry = '{rd: mc_rd, data: mc_data};

    assign mc_issue_ok = nrst && !pending_q[mc_issue_rd] && (outst_q < OW'(FIFO_DEPTH));
    assign issue_fire  = mc_issue && mc_issue_ok;
    assign id_hazard   = nrst && (pending_q[id_src1_addr] || pending_q[id_src2_addr] ||
                                  pending_q[id_dest_addr]);

    // Regfile write-port mux driven from the selected source.
    always_comb begin
        rf_wr_en     = 1'b0;
        rf_dest_addr = '0;
        rf_wr_data   = '0;
        case (sel)
            SEL_PIPE: begin
                rf_wr_en     = 1'b1;
                rf_dest_addr = pipe_wr_addr;
                rf_wr_data   = pipe_wr_data;
            end
            SEL_HEAD: begin
                rf_wr_en     = 1'b1;
                rf_dest_addr = head.rd;
                rf_wr_data   = head.data;
            end
            SEL_BYPASS: begin
                rf_wr_en     = bypass_wr;
                rf_dest_addr = mc_rd;
                rf_wr_data   = mc_data;
            end
            default: ;
        endcase
    end

    // Next state for scoreboard, outstanding count and starvation counter.
    always_comb begin
        pending_d = pending_q;
        if (pop)       pending_d[head.rd] = 1'b0;
        if (bypass_wr) pending_d[mc_rd]   = 1'b0;
        if (issue_fire && (mc_issue_rd != '0)) pending_d[mc_issue_rd] = 1'b1;

        // A pop and an x0 discard can retire two results in one cycle.
        outst_d = outst_q + OW'(issue_fire) - OW'(pop) - OW'(mc_retire);

        starve_d = '0;
        if (pipe_stall)
            starve_d = '0;
        else if (pipe_wr_en && !fifo_empty)
            starve_d = (starve_q < SW'(STARVE_LIM)) ? starve_q + 1'b1 : starve_q;
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            pending_q <= '0;
            outst_q   <= '0;
            starve_q  <= '0;
        end else begin
            pending_q <= pending_d;
            outst_q   <= outst_d;
            starve_q  <= starve_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a per-cycle vector table plus hand-written
// sequences for WB contention/forced drain and reset in the middle of operation.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        nrst;
    logic        pipe_wr_en;
    logic [4:0]  pipe_wr_addr;
    logic [31:0] pipe_wr_data;
    logic        mc_issue;
    logic [4:0]  mc_issue_rd;
    logic        mc_issue_ok;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic [4:0]  id_src1_addr, id_src2_addr, id_dest_addr;
    logic        id_hazard;
    logic        pipe_stall;
    logic        rf_wr_en;
    logic [4:0]  rf_dest_addr;
    logic [31:0] rf_wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIM(4)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .pipe_wr_en  (pipe_wr_en),
        .pipe_wr_addr(pipe_wr_addr),
        .pipe_wr_data(pipe_wr_data),
        .mc_issue    (mc_issue),
        .mc_issue_rd (mc_issue_rd),
        .mc_issue_ok (mc_issue_ok),
        .mc_valid    (mc_valid),
        .mc_rd       (mc_rd),
        .mc_data     (mc_data),
        .mc_ready    (mc_ready),
        .id_src1_addr(id_src1_addr),
        .id_src2_addr(id_src2_addr),
        .id_dest_addr(id_dest_addr),
        .id_hazard   (id_hazard),
        .pipe_stall  (pipe_stall),
        .rf_wr_en    (rf_wr_en),
        .rf_dest_addr(rf_dest_addr),
        .rf_wr_data  (rf_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        nrst;
        logic        pen;
        logic [4:0]  paddr;
        logic [31:0] pdata;
        logic        iss;
        logic [4:0]  ird;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic [4:0]  s1, s2, dst;
        logic        e_ok, e_rdy, e_haz, e_stall, e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One cycle: drive inputs just after the posedge, leave time to settle before checks.
    task automatic drive(input logic rn, input logic pen, input logic [4:0] paddr,
                         input logic [31:0] pdata, input logic iss, input logic [4:0] ird,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] dst);
        @(posedge clk);
        #1;
        nrst = rn; pipe_wr_en = pen; pipe_wr_addr = paddr; pipe_wr_data = pdata;
        mc_issue = iss; mc_issue_rd = ird; mc_valid = mv; mc_rd = mrd; mc_data = mdata;
        id_src1_addr = s1; id_src2_addr = s2; id_dest_addr = dst;
        #2;
    endtask

    initial begin
        //            nrst pen paddr pdata      iss ird mv mrd mdata          s1 s2 dst  ok rdy haz stl wen wa  wdata
        vecs[0]  = '{1'b0, 1, 1, 32'h11,    1, 3,  1, 4,  32'h44,        3, 4, 5,   0, 0, 0, 0, 0, 0,  32'h0};
        vecs[1]  = '{1'b0, 1, 1, 32'h11,    1, 3,  1, 4,  32'h44,        3, 4, 5,   0, 0, 0, 0, 0, 0,  32'h0};
        vecs[2]  = '{1'b1, 0, 0, 32'h0,     0, 0,  0, 0,  32'h0,         0, 0, 0,   1, 1, 0, 0, 0, 0,  32'h0};
        vecs[3]  = '{1'b1, 0, 0, 32'h0,     1, 5,  0, 0,  32'h0,         5, 0, 0,   1, 1, 0, 0, 0, 0,  32'h0};
        vecs[4]  = '{1'b1, 0, 0, 32'h0,     0, 5,  1, 5,  32'hDEADBEEF,  5, 0, 0,   0, 1, 1, 0, 1, 5,  32'hDEADBEEF};
        vecs[5]  = '{1'b1, 0, 0, 32'h0,     0, 5,  0, 0,  32'h0,         5, 0, 0,   1, 1, 0, 0, 0, 0,  32'h0};
        vecs[6]  = '{1'b1, 1, 2, 32'h1234,  0, 5,  0, 0,  32'h0,         0, 0, 0,   1, 1, 0, 0, 1, 2,  32'h1234};
        vecs[7]  = '{1'b1, 0, 0, 32'h0,     1, 9,  0, 0,  32'h0,         0, 9, 0,   1, 1, 0, 0, 0, 0,  32'h0};
        vecs[8]  = '{1'b1, 0, 0, 32'h0,     1, 9,  0, 0,  32'h0,         0, 9, 0,   0, 1, 1, 0, 0, 0,  32'h0};
        vecs[9]  = '{1'b1, 0, 0, 32'h0,     0, 9,  0, 0,  32'h0,         0, 0, 9,   0, 1, 1, 0, 0, 0,  32'h0};
        vecs[10] = '{1'b1, 1, 9, 32'h99,    0, 9,  1, 9,  32'h900D,      0, 9, 0,   0, 1, 1, 0, 1, 9,  32'h99};
        vecs[11] = '{1'b1, 0, 0, 32'h0,     0, 9,  0, 0,  32'h0,         0, 9, 0,   0, 1, 1, 0, 1, 9,  32'h900D};
        vecs[12] = '{1'b1, 0, 0, 32'h0,     0, 9,  0, 0,  32'h0,         0, 9, 0,   1, 1, 0, 0, 0, 0,  32'h0};
        vecs[13] = '{1'b1, 0, 0, 32'h0,     1, 0,  0, 0,  32'h0,         0, 0, 0,   1, 1, 0, 0, 0, 0,  32'h0};
        vecs[14] = '{1'b1, 0, 0, 32'h0,     0, 0,  1, 0,  32'hBAD,       0, 0, 0,   1, 1, 0, 0, 0, 0,  32'h0};
        vecs[15] = '{1'b1, 0, 0, 32'h0,     1, 10, 0, 0,  32'h0,         0, 0, 0,   1, 1, 0, 0, 0, 0,  32'h0};
        vecs[16] = '{1'b1, 0, 0, 32'h0,     1, 11, 0, 0,  32'h0,         0, 0, 0,   1, 1, 0, 0, 0, 0,  32'h0};
        vecs[17] = '{1'b1, 0, 0, 32'h0,     0, 12, 0, 0,  32'h0,         0, 0, 0,   0, 1, 0, 0, 0, 0,  32'h0};
        vecs[18] = '{1'b1, 0, 0, 32'h0,     0, 12, 1, 10, 32'hA0,        0, 0, 0,   0, 1, 0, 0, 1, 10, 32'hA0};
        vecs[19] = '{1'b1, 0, 0, 32'h0,     0, 12, 1, 11, 32'hB0,        10, 11, 0, 1, 1, 1, 0, 1, 11, 32'hB0};
        vecs[20] = '{1'b1, 0, 0, 32'h0,     0, 12, 0, 0,  32'h0,         0, 11, 0,  1, 1, 0, 0, 0, 0,  32'h0};

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].nrst, vecs[i].pen, vecs[i].paddr, vecs[i].pdata, vecs[i].iss,
                  vecs[i].ird, vecs[i].mv, vecs[i].mrd, vecs[i].mdata,
                  vecs[i].s1, vecs[i].s2, vecs[i].dst);
            chk($sformatf("v%0d_issue_ok", i), 32'(mc_issue_ok), 32'(vecs[i].e_ok));
            chk($sformatf("v%0d_mc_ready", i), 32'(mc_ready),    32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_id_hazard", i), 32'(id_hazard),  32'(vecs[i].e_haz));
            chk($sformatf("v%0d_pipe_stall", i), 32'(pipe_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_rf_wr_en", i), 32'(rf_wr_en),    32'(vecs[i].e_wen));
            if (vecs[i].e_wen) begin
                chk($sformatf("v%0d_rf_addr", i), 32'(rf_dest_addr), 32'(vecs[i].e_waddr));
                chk($sformatf("v%0d_rf_data", i), rf_wr_data,       vecs[i].e_wdata);
            end
        end

        // Contention: WB writes x1 every cycle while x6, x7 complete and get buffered.
        drive(1, 1, 1, 32'h100, 1, 6, 0, 0, 32'h0, 0, 0, 0);
        chk("c_a_issue_ok", 32'(mc_issue_ok), 32'd1);
        chk("c_a_addr", 32'(rf_dest_addr), 32'd1);
        drive(1, 1, 1, 32'h101, 1, 7, 0, 0, 32'h0, 0, 0, 0);
        chk("c_b_issue_ok", 32'(mc_issue_ok), 32'd1);
        drive(1, 1, 1, 32'h102, 0, 0, 1, 6, 32'h600, 0, 0, 0);
        chk("c_c_ready", 32'(mc_ready), 32'd1);
        chk("c_c_data", rf_wr_data, 32'h102);
        drive(1, 1, 1, 32'h103, 0, 0, 1, 7, 32'h700, 0, 0, 0);
        chk("c_d_ready", 32'(mc_ready), 32'd1);
        chk("c_d_stall", 32'(pipe_stall), 32'd0);
        drive(1, 1, 1, 32'h104, 0, 0, 1, 8, 32'h800, 0, 0, 0);
        chk("c_e_ready_full", 32'(mc_ready), 32'd0);
        chk("c_e_stall", 32'(pipe_stall), 32'd0);
        drive(1, 1, 1, 32'h104, 0, 0, 1, 8, 32'h800, 0, 0, 0);
        chk("c_f_ready_full", 32'(mc_ready), 32'd0);
        drive(1, 1, 1, 32'h104, 0, 8, 1, 8, 32'h800, 0, 0, 0);
        chk("c_g_ready_full", 32'(mc_ready), 32'd0);
        chk("c_g_stall", 32'(pipe_stall), 32'd0);
        chk("c_g_issue_ok_outst", 32'(mc_issue_ok), 32'd0);
        chk("c_g_data", rf_wr_data, 32'h104);
        drive(1, 1, 1, 32'h105, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        chk("c_h_stall", 32'(pipe_stall), 32'd1);
        chk("c_h_wr_en", 32'(rf_wr_en), 32'd1);
        chk("c_h_addr", 32'(rf_dest_addr), 32'd6);
        chk("c_h_data", rf_wr_data, 32'h600);
        chk("c_h_ready", 32'(mc_ready), 32'd1);
        drive(1, 1, 1, 32'h106, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        chk("c_i_stall", 32'(pipe_stall), 32'd0);
        chk("c_i_data", rf_wr_data, 32'h106);
        drive(1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        chk("c_j_wr_en", 32'(rf_wr_en), 32'd1);
        chk("c_j_addr", 32'(rf_dest_addr), 32'd7);
        chk("c_j_data", rf_wr_data, 32'h700);
        drive(1, 0, 0, 32'h0, 0, 7, 0, 0, 32'h0, 6, 7, 0);
        chk("c_k_wr_en", 32'(rf_wr_en), 32'd0);
        chk("c_k_hazard", 32'(id_hazard), 32'd0);
        chk("c_k_issue_ok", 32'(mc_issue_ok), 32'd1);

        // Reset mid-operation with two buffered results and two pending registers.
        drive(1, 1, 3, 32'h200, 1, 12, 0, 0, 32'h0, 0, 0, 0);
        drive(1, 1, 3, 32'h201, 1, 13, 0, 0, 32'h0, 0, 0, 0);
        drive(1, 1, 3, 32'h202, 0, 0, 1, 12, 32'h1200, 0, 0, 0);
        chk("r_push1_ready", 32'(mc_ready), 32'd1);
        drive(1, 1, 3, 32'h203, 0, 0, 1, 13, 32'h1300, 12, 0, 0);
        chk("r_push2_ready", 32'(mc_ready), 32'd1);
        chk("r_pre_hazard", 32'(id_hazard), 32'd1);
        drive(0, 1, 3, 32'h204, 1, 14, 1, 14, 32'h1400, 12, 0, 0);
        chk("r_rst_wr_en", 32'(rf_wr_en), 32'd0);
        chk("r_rst_ready", 32'(mc_ready), 32'd0);
        chk("r_rst_issue_ok", 32'(mc_issue_ok), 32'd0);
        chk("r_rst_hazard", 32'(id_hazard), 32'd0);
        chk("r_rst_stall", 32'(pipe_stall), 32'd0);
        drive(1, 0, 0, 32'h0, 0, 12, 0, 0, 32'h0, 12, 13, 0);
        chk("r_post_wr_en", 32'(rf_wr_en), 32'd0);
        chk("r_post_hazard", 32'(id_hazard), 32'd0);
        chk("r_post_issue_ok", 32'(mc_issue_ok), 32'd1);
        chk("r_post_ready", 32'(mc_ready), 32'd1);
        drive(1, 0, 0, 32'h0, 0, 13, 0, 0, 32'h0, 0, 0, 0);
        chk("r_post2_wr_en", 32'(rf_wr_en), 32'd0);
        chk("r_post2_issue_ok", 32'(mc_issue_ok), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
